// File: rtl/apple1_term_pkg.sv
// Shared definitions for the Apple-1 terminal character path: character width
// and the sender handshake state encoding.
package apple1_term_pkg;

   localparam int CHAR_W = 7;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      STROBE    = 2'd1,
      WAIT_ACK  = 2'd2,
      WAIT_DONE = 2'd3
   } term_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; full/empty are plain compares of the
// registered pointers. A push while full is dropped, a pop while empty is ignored.
module sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 7
) (
   input  logic             cp,
   input  logic             mr,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign empty     = (r_wr_ptr == r_rd_ptr);
   assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_push_ok = push && !full;
   assign w_pop_ok  = pop && !empty;
   assign pop_data  = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge cp) begin
      if (mr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset: entries are only readable once the pointers cover them.
   always_ff @(posedge cp) begin
      if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/apple1_char_sender.sv
// Host-side character transmitter for the Apple-1 terminal: queues characters and
// hands them over one at a time with the DA/RDA strobe handshake.
import apple1_term_pkg::*;

module apple1_char_sender #(
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic              cp,
   input  logic              mr,
   input  logic              wr_en,
   input  logic [CHAR_W-1:0] wr_data,
   output logic              full,
   output logic              empty,
   output logic [CHAR_W-1:0] d,
   output logic              da,
   input  logic              rda,
   output logic              busy,
   output logic              timeout
);

   localparam int CNT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

   term_state_e       r_state;
   logic [CHAR_W-1:0] r_d;
   logic              r_da;
   logic              r_timeout;
   logic [CNT_W-1:0]  r_cnt;
   logic              w_rda_s;
   logic              w_pop;
   logic              w_empty;
   logic [CHAR_W-1:0] w_head;

   sync_fifo #(.DEPTH(DEPTH), .WIDTH(CHAR_W)) u_fifo (
      .cp        (cp),
      .mr        (mr),
      .push      (wr_en),
      .push_data (wr_data),
      .pop       (w_pop),
      .pop_data  (w_head),
      .full      (full),
      .empty     (w_empty)
   );

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign w_rda_s = rda;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] r_sync;
         always_ff @(posedge cp) begin
            if (mr) begin
               r_sync <= '0;
            end else begin
               r_sync[0] <= rda;
               for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            end
         end
         assign w_rda_s = r_sync[SYNC_STAGES-1];
      end
   endgenerate

   // A still-busy terminal holds the queue; the pop and the load of d happen together.
   assign w_pop = (r_state == IDLE) && !w_empty && !w_rda_s;

   always_ff @(posedge cp) begin
      if (mr) begin
         r_state   <= IDLE;
         r_d       <= '0;
         r_da      <= 1'b0;
         r_timeout <= 1'b0;
         r_cnt     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_pop) begin
                  r_d     <= w_head;
                  r_state <= STROBE;
               end
            end
            STROBE: begin
               r_da    <= 1'b1;
               r_cnt   <= '0;
               r_state <= WAIT_ACK;
            end
            WAIT_ACK: begin
               if (w_rda_s) begin
                  r_da    <= 1'b0;
                  r_state <= WAIT_DONE;
               end else if (ACK_TIMEOUT != 0 && r_cnt == CNT_W'(ACK_TIMEOUT)) begin
                  r_da      <= 1'b0;
                  r_timeout <= 1'b1;
                  r_state   <= IDLE;
               end else if (r_cnt != '1) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (!w_rda_s) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign empty   = w_empty;
   assign d       = r_d;
   assign da      = r_da;
   assign busy    = (r_state != IDLE);
   assign timeout = r_timeout;

endmodule

// File: tb/tb_apple1_char_sender.sv
// Directed bench for apple1_char_sender: a scripted or auto-responding terminal
// model and a negedge monitor that logs every character strobed out.
module tb_apple1_char_sender;

   logic       cp;
   logic       mr;
   logic       wr_en;
   logic [6:0] wr_data;
   logic       full;
   logic       empty;
   logic [6:0] d;
   logic       da;
   logic       rda;
   logic       busy;
   logic       timeout;

   logic       rda_man;
   logic       rda_auto;
   logic       auto_en;
   int         ack_dly;

   int         n_vec;
   int         n_err;
   logic [6:0] sent[$];
   logic       da_q;
   logic [6:0] d_q;
   int         d_glitch;

   apple1_char_sender #(.DEPTH(4), .SYNC_STAGES(2), .ACK_TIMEOUT(8)) dut (
      .cp      (cp),
      .mr      (mr),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .full    (full),
      .empty   (empty),
      .d       (d),
      .da      (da),
      .rda     (rda),
      .busy    (busy),
      .timeout (timeout)
   );

   assign rda = auto_en ? rda_auto : rda_man;

   initial begin
      cp = 1'b0;
      forever #5 cp = ~cp;
   end

   // Log each character on the rising edge of da; d must not move while da is high.
   initial begin
      da_q     = 1'b0;
      d_q      = '0;
      d_glitch = 0;
   end
   always @(negedge cp) begin
      if (da === 1'b1 && da_q === 1'b0) sent.push_back(d);
      if (da === 1'b1 && da_q === 1'b1 && d !== d_q) d_glitch <= d_glitch + 1;
      da_q <= da;
      d_q  <= d;
   end

   // Terminal model: takes the character ack_dly cycles after da, holds rda until da drops.
   initial begin
      rda_auto = 1'b0;
      forever begin
         @(posedge cp); #1;
         if (auto_en && da) begin
            repeat (ack_dly) @(posedge cp);
            #1 rda_auto = 1'b1;
            for (int k = 0; k < 50 && da; k++) begin
               @(posedge cp); #1;
            end
            repeat (2) @(posedge cp);
            #1 rda_auto = 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [6:0] c);
      wr_en   = 1'b1;
      wr_data = c;
      @(posedge cp); #1;
      wr_en   = 1'b0;
   endtask

   task automatic wait_sent(input int n, input int budget);
      for (int k = 0; k < budget && sent.size() < n; k++) begin
         @(posedge cp); #1;
      end
   endtask

   task automatic wait_idle(input int budget);
      for (int k = 0; k < budget && busy; k++) begin
         @(posedge cp); #1;
      end
   endtask

   initial begin
      int lat;
      int n;
      int base;
      n_vec   = 0;
      n_err   = 0;
      mr      = 1'b1;
      wr_en   = 1'b1;
      wr_data = 7'h55;
      rda_man = 1'b0;
      auto_en = 1'b0;
      ack_dly = 1;

      // 1: reset wins over a simultaneous push
      repeat (3) @(posedge cp);
      #1 wr_en = 1'b0;
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_da", da, 0);
      chk("rst_d", d, 0);
      chk("rst_busy", busy, 0);
      chk("rst_timeout", timeout, 0);
      mr = 1'b0;
      @(posedge cp); #1;
      chk("rst_empty_after", empty, 1);

      // 2: single character, terminal acks 5 cycles after da
      wr_data = 7'h41;
      wr_en   = 1'b1;
      lat     = 0;
      do begin
         @(posedge cp); #1;
         wr_en = 1'b0;
         lat++;
      end while (!da && lat < 20);
      chk("t2_da_latency", lat, 3);
      chk("t2_d", d, 7'h41);
      chk("t2_busy", busy, 1);
      repeat (5) @(posedge cp);
      #1 rda_man = 1'b1;
      n = 0;
      do begin
         @(posedge cp); #1;
         n++;
      end while (da && n < 20);
      // two synchroniser flops, then the FSM's registered response
      chk("t2_da_fall", n, 3);
      repeat (7) @(posedge cp);
      #1 rda_man = 1'b0;
      wait_idle(20);
      chk("t2_busy_end", busy, 0);
      chk("t2_nsent", sent.size(), 1);
      if (sent.size() >= 1) chk("t2_char", sent[0], 7'h41);

      // 3: overflow with the terminal stuck busy
      rda_man = 1'b1;
      repeat (3) @(posedge cp);
      #1;
      base = sent.size();
      for (int i = 0; i < 5; i++) begin
         push(7'(7'h41 + i));
         chk($sformatf("t3_full_%0d", i), full, (i >= 3) ? 1 : 0);
      end
      chk("t3_nosend_busy", sent.size(), base);
      rda_man = 1'b0;
      auto_en = 1'b1;
      wait_sent(base + 4, 300);
      repeat (40) @(posedge cp);
      #1;
      chk("t3_nsent", sent.size(), base + 4);
      for (int k = 0; k < 4; k++)
         if (base + k < sent.size()) chk($sformatf("t3_char_%0d", k), sent[base+k], 7'(7'h41 + k));
      chk("t3_empty_end", empty, 1);

      // 4: push coinciding with the pop, FIFO at 2 entries
      auto_en = 1'b0;
      rda_man = 1'b1;
      repeat (3) @(posedge cp);
      #1;
      base = sent.size();
      push(7'h21);
      push(7'h22);
      rda_man = 1'b0;
      repeat (2) @(posedge cp);
      #1;
      push(7'h23);
      chk("t4_full_a", full, 0);
      chk("t4_empty_a", empty, 0);
      push(7'h24);
      chk("t4_full_b", full, 0);
      push(7'h25);
      chk("t4_full_c", full, 1);
      auto_en = 1'b1;
      wait_sent(base + 5, 400);
      chk("t4_nsent", sent.size(), base + 5);
      for (int k = 0; k < 5; k++)
         if (base + k < sent.size()) chk($sformatf("t4_char_%0d", k), sent[base+k], 7'(7'h21 + k));
      wait_idle(40);
      base = sent.size();
      for (int i = 0; i < 20; i++) begin
         for (int k = 0; k < 200 && full; k++) begin
            @(posedge cp); #1;
         end
         push(7'(7'h50 + i));
      end
      wait_sent(base + 20, 2000);
      chk("t4_wrap_nsent", sent.size(), base + 20);
      for (int k = 0; k < 20; k++)
         if (base + k < sent.size()) chk($sformatf("t4_wrap_%0d", k), sent[base+k], 7'(7'h50 + k));
      wait_idle(40);

      // 5: ack timeout, then normal traffic with the flag still set
      auto_en = 1'b0;
      rda_man = 1'b0;
      chk("t5_timeout_pre", timeout, 0);
      push(7'h30);
      n = 0;
      while (!da && n < 20) begin
         @(posedge cp); #1;
         n++;
      end
      lat = 0;
      while (da && lat < 40) begin
         lat++;
         @(posedge cp); #1;
      end
      chk("t5_da_high", lat, 9);
      chk("t5_timeout", timeout, 1);
      chk("t5_da_low", da, 0);
      chk("t5_busy", busy, 0);
      auto_en = 1'b1;
      base    = sent.size();
      push(7'h31);
      wait_sent(base + 1, 100);
      wait_idle(40);
      chk("t5_next_nsent", sent.size(), base + 1);
      if (sent.size() > base) chk("t5_next_char", sent[base], 7'h31);
      chk("t5_timeout_sticky", timeout, 1);

      // 6: reset while waiting for the ack with 3 characters queued
      auto_en = 1'b0;
      rda_man = 1'b0;
      for (int i = 0; i < 4; i++) push(7'(7'h60 + i));
      chk("t6_pre_da", da, 1);
      chk("t6_pre_empty", empty, 0);
      mr = 1'b1;
      @(posedge cp); #1;
      chk("t6_da", da, 0);
      chk("t6_empty", empty, 1);
      chk("t6_busy", busy, 0);
      chk("t6_timeout", timeout, 0);
      chk("t6_d", d, 0);
      mr      = 1'b0;
      auto_en = 1'b1;
      base    = sent.size();
      repeat (40) @(posedge cp);
      #1;
      chk("t6_nothing_sent", sent.size(), base);

      chk("d_stable_under_da", d_glitch, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
